// File: rtl/mat_argmax.sv
// Argmax over an IEEE-754 single-precision matrix: latches the matrix, scans N_CMP
// elements per cycle, and returns the flat index and bit pattern of the maximum.
module mat_argmax #(
    parameter int M     = 1,
    parameter int N     = 1,
    parameter int N_CMP = 1,
    localparam int TOTAL = M * N,
    localparam int IW    = (TOTAL > 1) ? $clog2(TOTAL) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [M-1:0][N-1:0][31:0] input_mat,
    input  logic                      input_mat_stb,
    input  logic                      output_ack,
    output logic                      input_mat_ack,
    output logic [IW-1:0]             output_index,
    output logic [31:0]               output_value,
    output logic                      output_stb
);

    localparam int NB  = (TOTAL + N_CMP - 1) / N_CMP;
    localparam int CW  = (NB > 1) ? $clog2(NB) : 1;
    localparam int KW  = (NB * N_CMP > 1) ? $clog2(NB * N_CMP) : 1;
    localparam int PAD = 1 << KW;

    typedef enum logic [1:0] {GET_MAT, SCAN, PUT_RES} state_t;

    state_t                  state, state_nx;
    logic [TOTAL-1:0][31:0]  mat_q;
    logic [PAD-1:0][31:0]    padded;
    logic [CW-1:0]           cnt;
    logic [31:0]             best_val, scan_val;
    logic [IW-1:0]           best_idx, scan_idx;
    logic                    last;
    logic                    xfer;

    function automatic logic is_nan(input logic [31:0] x);
        return (&x[30:23]) && (|x[22:0]);
    endfunction

    // Sign-magnitude mapped onto a signed integer; -0 and +0 both become 0.
    function automatic logic signed [32:0] ord(input logic [31:0] x);
        logic signed [32:0] mag;
        mag = $signed({2'b00, x[30:0]});
        return x[31] ? -mag : mag;
    endfunction

    function automatic logic beats(input logic [31:0] e, input logic [31:0] b);
        return !is_nan(e) && (is_nan(b) || (ord(e) > ord(b)));
    endfunction

    // Pad to a power of two so the lane index needs no range guard on the array.
    for (genvar p = 0; p < PAD; p++) begin : g_pad
        if (p < TOTAL) begin : g_v
            assign padded[p] = mat_q[p];
        end else begin : g_z
            assign padded[p] = '0;
        end
    end

    assign last = (cnt == CW'(NB - 1));
    assign xfer = input_mat_ack && input_mat_stb;

    // Lanes chained in ascending k with strict greater-than, so ties keep the lowest k.
    always_comb begin
        scan_val = best_val;
        scan_idx = best_idx;
        for (int l = 0; l < N_CMP; l++) begin
            if (int'(cnt) * N_CMP + l < TOTAL) begin
                if (beats(padded[KW'(int'(cnt) * N_CMP + l)], scan_val)) begin
                    scan_val = padded[KW'(int'(cnt) * N_CMP + l)];
                    scan_idx = IW'(int'(cnt) * N_CMP + l);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= GET_MAT;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            GET_MAT: if (xfer) state_nx = SCAN;
            SCAN:    if (last) state_nx = PUT_RES;
            PUT_RES: if (output_stb && output_ack) state_nx = GET_MAT;
            default: state_nx = GET_MAT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            input_mat_ack <= 1'b0;
            output_stb    <= 1'b0;
            output_index  <= '0;
            output_value  <= '0;
            cnt           <= '0;
            best_val      <= '0;
            best_idx      <= '0;
            mat_q         <= '0;
        end else begin
            case (state)
                GET_MAT: begin
                    if (xfer) begin
                        mat_q         <= input_mat;
                        input_mat_ack <= 1'b0;
                        best_val      <= input_mat[0][0];
                        best_idx      <= '0;
                        cnt           <= '0;
                    end else begin
                        input_mat_ack <= 1'b1;
                    end
                end
                SCAN: begin
                    best_val <= scan_val;
                    best_idx <= scan_idx;
                    cnt      <= last ? '0 : cnt + 1'b1;
                end
                PUT_RES: begin
                    if (!output_stb) begin
                        output_stb   <= 1'b1;
                        output_index <= best_idx;
                        output_value <= best_val;
                    end else if (output_ack) begin
                        output_stb <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
